// File: rtl/cache_port_arbiter.sv
// Two-port arbiter in front of a single direct-mapped cache, round-robin on contention.
// Optional hit/access statistics built only when CACHE_ARB_STATS_EN is defined.
module cache_port_arbiter #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done0,
  output logic              done1,
  output logic              hit0,
  output logic              hit1,
  output logic              cache_start,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_finish,
  input  logic              cache_hit,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  acc_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state, w_next;
  logic              r_owner, r_ptr, r_hit;
  logic [ADDR_W-1:0] r_addr;
  logic              w_grant;

  // Contention goes to the pointer; otherwise whichever port is asking.
  assign w_grant = (req0 && req1) ? r_ptr : req1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req0 || req1) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (cache_finish) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_hit   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req0 || req1) begin
          r_owner <= w_grant;
          r_addr  <= w_grant ? addr1 : addr0;
        end
        WAIT: if (cache_finish) r_hit <= cache_hit;
        RESP: r_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign cache_start = (r_state == ISSUE);
  assign cache_addr  = r_addr;
  assign done0       = (r_state == RESP) && !r_owner;
  assign done1       = (r_state == RESP) &&  r_owner;
  assign hit0        = done0 && r_hit;
  assign hit1        = done1 && r_hit;

`ifdef CACHE_ARB_STATS_EN
  logic [CNT_W-1:0] r_hit_cnt, r_acc_cnt;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt <= '0;
      r_acc_cnt <= '0;
    end else if (r_state == RESP) begin
      r_acc_cnt <= r_acc_cnt + 1'b1;
      if (r_hit) r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign hit_cnt = r_hit_cnt;
  assign acc_cnt = r_acc_cnt;
`else
  assign hit_cnt = '0;
  assign acc_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with an expected-grant scoreboard queue.
module tb_cache_port_arbiter;
  localparam int ADDR_W = 15;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0, rst = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              done0, done1, hit0, hit1, cache_start, busy;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_finish = 1'b0, cache_hit = 1'b0;
  logic [CNT_W-1:0]  hit_cnt, acc_cnt;

  cache_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .done0(done0), .done1(done1), .hit0(hit0), .hit1(hit1),
    .cache_start(cache_start), .cache_addr(cache_addr),
    .cache_finish(cache_finish), .cache_hit(cache_hit), .busy(busy),
    .hit_cnt(hit_cnt), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic              hit;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   exp_acc = 0, exp_hit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic [ADDR_W-1:0] a, input logic h);
    exp_t e;
    e.port = p; e.addr = a; e.hit = h;
    sb.push_back(e);
  endtask

  task automatic chk_stats(input string tag);
`ifdef CACHE_ARB_STATS_EN
    chk({tag, "_acc"}, 32'(acc_cnt), exp_acc);
    chk({tag, "_hit"}, 32'(hit_cnt), exp_hit);
`else
    chk({tag, "_acc"}, 32'(acc_cnt), 0);
    chk({tag, "_hit"}, 32'(hit_cnt), 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    exp_acc = 0; exp_hit = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'({done0, done1, hit0, hit1}), 0);
    chk("rst_start", 32'(cache_start), 0);
    chk("rst_addr", 32'(cache_addr), 0);
    chk_stats("rst");
    tick(); tick();
    rst = 1'b1;
  endtask

  // Serve one access: wait for launch, check address, model the cache, check done.
  task automatic serve(input int stall, input int drop0_at, input int raise1_at);
    exp_t e;
    bit   seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (cache_start) seen = 1;
    end
    chk("start_seen", 32'(seen), 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("start_addr", 32'(cache_addr), 32'(e.addr));
    cache_hit    = e.hit;
    cache_finish = 1'b0;
    tick();
    for (int k = 0; k < stall; k++) begin
      if (k == drop0_at)  req0 = 1'b0;
      if (k == raise1_at) req1 = 1'b1;
      tick();
      chk("stall_quiet", 32'({cache_start, done0, done1}), 0);
    end
    cache_finish = 1'b1;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (done0 || done1) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
    chk("done_port", 32'({done1, done0}), e.port ? 2 : 1);
    chk("done_hit",  32'({hit1, hit0}), e.hit ? (e.port ? 2 : 1) : 0);
    chk("resp_addr", 32'(cache_addr), 32'(e.addr));
    cache_finish = 1'b0;
    exp_acc++;
    if (e.hit) exp_hit++;
  endtask

  initial begin
    do_reset();

    // Single request, exact cycle timing.
    addr0 = 15'h1234; req0 = 1'b1;
    tick();
    chk("c1_start", 32'(cache_start), 1);
    chk("c1_addr", 32'(cache_addr), 32'h1234);
    chk("c1_busy", 32'(busy), 1);
    cache_finish = 1'b1; cache_hit = 1'b1;
    tick();
    chk("c2_start_off", 32'(cache_start), 0);
    chk("c2_no_done", 32'({done0, done1}), 0);
    tick();
    chk("c3_done0", 32'(done0), 1);
    chk("c3_hit0", 32'(hit0), 1);
    chk("c3_done1", 32'(done1), 0);
    req0 = 1'b0; cache_finish = 1'b0; cache_hit = 1'b0;
    exp_acc++; exp_hit++;
    tick();
    chk("c4_idle", 32'({busy, done0, hit0}), 0);
    chk("c4_addr_hold", 32'(cache_addr), 32'h1234);
    chk_stats("single");

    // Contention: alternation from a fresh pointer.
    do_reset();
    addr0 = 15'h00AA; addr1 = 15'h0155;
    req0 = 1'b1; req1 = 1'b1;
    push(1'b0, 15'h00AA, 1'b1);
    push(1'b1, 15'h0155, 1'b0);
    push(1'b0, 15'h00AA, 1'b1);
    push(1'b1, 15'h0155, 1'b0);
    for (int n = 0; n < 4; n++) serve(0, -1, -1);
    req0 = 1'b0; req1 = 1'b0;
    req0 = 1'b1; addr0 = 15'h7001;
    push(1'b0, 15'h7001, 1'b1);
    serve(1, -1, -1);
    req0 = 1'b0;
    tick(); tick();
    chk_stats("five");
    chk("idle_after", 32'(busy), 0);

    // Long stall; req0 drops mid-access, req1 arrives while busy.
    addr0 = 15'h0321; addr1 = 15'h4567;
    req0 = 1'b1;
    push(1'b0, 15'h0321, 1'b0);
    push(1'b1, 15'h4567, 1'b1);
    serve(10, 2, 5);
    serve(0, -1, -1);
    req1 = 1'b0;
    tick(); tick();

    // Stray cache_finish in IDLE.
    cache_finish = 1'b1; cache_hit = 1'b1;
    tick(); tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_done", 32'({done0, done1, cache_start}), 0);
    cache_finish = 1'b0; cache_hit = 1'b0;
    chk_stats("stray");

    // Reset in WAIT abandons the access.
    addr0 = 15'h07FF; req0 = 1'b1;
    tick();
    chk("ab_start", 32'(cache_start), 1);
    tick();
    chk("ab_wait", 32'({busy, cache_start}), 2);
    cache_finish = 1'b1; cache_hit = 1'b1;
    rst = 1'b0;
    #1;
    chk("ab_async_busy", 32'(busy), 0);
    chk("ab_async_out", 32'({done0, done1, hit0, hit1, cache_start}), 0);
    chk("ab_async_addr", 32'(cache_addr), 0);
    exp_acc = 0; exp_hit = 0;
    tick();
    chk("ab_no_done", 32'({done0, done1}), 0);
    cache_finish = 1'b0; cache_hit = 1'b0;
    tick();
    chk_stats("ab");
    rst = 1'b1;
    push(1'b0, 15'h07FF, 1'b0);
    serve(0, -1, -1);
    req0 = 1'b0;
    tick(); tick();
    chk_stats("post_ab");
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
